// File: rtl/game_pkg.sv
// Shared game constants, encodings and tile-index helper for the game-logic blocks.
package game_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int TILE_SHIFT = 4;
  localparam int RATIO      = 1 << TILE_SHIFT;  // pixels per tile edge
  localparam int N_TILES    = GRID_W * GRID_H;
  localparam int TILE_IDX_W = 11;

  localparam logic [TILE_IDX_W-1:0] TILE_NONE = '1;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    SPRITE_PACMAN,
    SPRITE_GHOST,
    SPRITE_PELLET,
    SPRITE_WALL
  } sprite_id_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_EAT
  } pellet_state_e;

  function automatic logic [TILE_IDX_W-1:0] tile_index(input logic [5:0] tx,
                                                       input logic [4:0] ty);
    return TILE_IDX_W'(ty) * TILE_IDX_W'(GRID_W) + TILE_IDX_W'(tx);
  endfunction

endpackage

// File: rtl/pellet_bitmap.sv
// One-bit-per-tile pellet store: one sync write port, one combinational FSM read port,
// one registered renderer read port.
module pellet_bitmap
  import game_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [TILE_IDX_W-1:0] wr_addr_i,
  input  logic                  wr_data_i,
  input  logic [TILE_IDX_W-1:0] fsm_addr_i,
  output logic                  fsm_data_o,
  input  logic                  rd_en_i,
  input  logic [TILE_IDX_W-1:0] rd_addr_i,
  output logic                  rd_data_o
);

  logic mem_q [N_TILES];
  logic rd_q;

  // NOTE: the array has no reset; INIT rewrites every entry before init_done rises.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign fsm_data_o = mem_q[fsm_addr_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 1'b0;
    else     rd_q <= rd_en_i ? mem_q[rd_addr_i] : 1'b0;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/pellet_tracker.sv
// Pellet tracker: loads the pellet bitmap from the wall ROM, clears pellets as pacman
// enters tiles, and keeps a saturating score plus pellets-remaining / level-clear status.
module pellet_tracker
  import game_pkg::*;
#(
  parameter int SCORE_W       = 12,
  parameter int PELLET_POINTS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        pacman_pos_x,
  input  logic [9:0]         pacman_pos_y,
  input  logic               score_clear,
  input  logic               level_restart,
  output logic [10:0]        wall_addr,
  input  logic               wall_is_wall,
  input  logic [5:0]         rd_tile_x,
  input  logic [4:0]         rd_tile_y,
  output logic               rd_pellet,
  output logic [SCORE_W-1:0] score,
  output logic [10:0]        pellets_left,
  output logic               eat_pulse,
  output logic               init_done,
  output logic               level_clear
);

  localparam logic [TILE_IDX_W-1:0] LAST_INIT  = TILE_IDX_W'(N_TILES);
  localparam logic [SCORE_W-1:0]    SCORE_MAX  = '1;
  localparam logic [SCORE_W:0]      SCORE_STEP = (SCORE_W+1)'(PELLET_POINTS);

  pellet_state_e            state_q, state_d;
  logic [TILE_IDX_W-1:0]    cnt_q, cnt_d;
  logic [TILE_IDX_W-1:0]    idx_q, idx_d;
  logic [TILE_IDX_W-1:0]    last_tile_q, last_tile_d;
  logic                     bit_q, bit_d;
  logic [10:0]              pellets_q, pellets_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic                     eat_q, eat_d;
  logic                     init_done_q, init_done_d;
  logic                     level_clear_q, level_clear_d;

  logic [10:0]              pac_tx;
  logic [9:0]               pac_ty;
  logic                     pac_valid;
  logic [TILE_IDX_W-1:0]    pac_idx;
  logic                     rd_valid;
  logic [TILE_IDX_W-1:0]    rd_addr;
  logic [SCORE_W:0]         score_sum;
  logic [SCORE_W-1:0]       score_sat;

  logic                     wr_en;
  logic [TILE_IDX_W-1:0]    wr_addr;
  logic                     wr_data;
  logic                     fsm_data;

  assign pac_tx    = pacman_pos_x >> TILE_SHIFT;
  assign pac_ty    = pacman_pos_y >> TILE_SHIFT;
  assign pac_valid = (pac_tx < 11'(GRID_W)) && (pac_ty < 10'(GRID_H));
  assign pac_idx   = tile_index(pac_tx[5:0], pac_ty[4:0]);

  assign rd_valid  = init_done_q && (rd_tile_x < 6'(GRID_W)) && (rd_tile_y < 5'(GRID_H));
  assign rd_addr   = tile_index(rd_tile_x, rd_tile_y);

  assign score_sum = {1'b0, score_q} + SCORE_STEP;
  assign score_sat = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  pellet_bitmap u_bitmap (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .fsm_addr_i (idx_q),
    .fsm_data_o (fsm_data),
    .rd_en_i    (rd_valid),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_pellet)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    last_tile_d   = last_tile_q;
    bit_d         = bit_q;
    pellets_d     = pellets_q;
    score_d       = score_q;
    eat_d         = 1'b0;
    init_done_d   = init_done_q;
    level_clear_d = level_clear_q | (init_done_q && (pellets_q == 11'd0));
    wr_en         = 1'b0;
    wr_addr       = idx_q;
    wr_data       = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 11'd1;
        // ROM data returning this cycle belongs to the address driven last cycle
        if (cnt_q != '0) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q - 11'd1;
          wr_data = ~wall_is_wall;
          if (!wall_is_wall) pellets_d = pellets_q + 11'd1;
        end
        if (cnt_q == LAST_INIT) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (pac_valid && (pac_idx != last_tile_q)) begin
          idx_d       = pac_idx;
          last_tile_d = pac_idx;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        bit_d   = fsm_data;
        state_d = ST_EAT;
      end
      ST_EAT: begin
        state_d = ST_IDLE;
        if (bit_q) begin
          wr_en     = 1'b1;
          wr_addr   = idx_q;
          wr_data   = 1'b0;
          pellets_d = pellets_q - 11'd1;
          score_d   = score_sat;
          eat_d     = 1'b1;
        end
      end
    endcase

    if (level_restart) begin
      state_d       = ST_INIT;
      cnt_d         = '0;
      pellets_d     = '0;
      init_done_d   = 1'b0;
      level_clear_d = 1'b0;
      last_tile_d   = TILE_NONE;
      score_d       = score_q;
      eat_d         = 1'b0;
      wr_en         = 1'b0;
    end

    if (score_clear) score_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      idx_q         <= '0;
      last_tile_q   <= TILE_NONE;
      bit_q         <= 1'b0;
      pellets_q     <= '0;
      score_q       <= '0;
      eat_q         <= 1'b0;
      init_done_q   <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      last_tile_q   <= last_tile_d;
      bit_q         <= bit_d;
      pellets_q     <= pellets_d;
      score_q       <= score_d;
      eat_q         <= eat_d;
      init_done_q   <= init_done_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign wall_addr    = cnt_q;
  assign score        = score_q;
  assign pellets_left = pellets_q;
  assign eat_pulse    = eat_q;
  assign init_done    = init_done_q;
  assign level_clear  = level_clear_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: init from a modelled wall ROM, eating, re-entry,
// score clear/saturation, level clear/restart, range limits and async reset.
module tb_pellet_tracker;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] pacman_pos_x;
  logic [9:0]  pacman_pos_y;
  logic        score_clear;
  logic        level_restart;
  logic [10:0] wall_addr;
  logic        wall_is_wall = 1'b0;
  logic [5:0]  rd_tile_x;
  logic [4:0]  rd_tile_y;
  logic        rd_pellet;
  logic [11:0] score;
  logic [10:0] pellets_left;
  logic        eat_pulse;
  logic        init_done;
  logic        level_clear;

  int n_vec = 0;
  int n_bad = 0;
  int rom_mode = 0;  // 0: only tile 0 is wall, 1: all walls except tile 5, 2: no walls

  pellet_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .pacman_pos_x  (pacman_pos_x),
    .pacman_pos_y  (pacman_pos_y),
    .score_clear   (score_clear),
    .level_restart (level_restart),
    .wall_addr     (wall_addr),
    .wall_is_wall  (wall_is_wall),
    .rd_tile_x     (rd_tile_x),
    .rd_tile_y     (rd_tile_y),
    .rd_pellet     (rd_pellet),
    .score         (score),
    .pellets_left  (pellets_left),
    .eat_pulse     (eat_pulse),
    .init_done     (init_done),
    .level_clear   (level_clear)
  );

  always #5 clk = ~clk;

  function automatic logic rom_wall(input logic [10:0] a);
    case (rom_mode)
      0:       return a == 11'd0;
      1:       return a != 11'd5;
      default: return 1'b0;
    endcase
  endfunction

  // Wall ROM model: data valid one cycle after the address.
  always @(posedge clk) wall_is_wall <= rom_wall(wall_addr);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 3000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic step_tile(input int x, input int y, output int pulses);
    pacman_pos_x = 11'(x);
    pacman_pos_y = 10'(y);
    pulses = 0;
    repeat (4) begin
      tick();
      if (eat_pulse) pulses++;
    end
  endtask

  task automatic sweep(input int first, input int last, output int pulses);
    int p;
    pulses = 0;
    for (int i = first; i <= last; i++) begin
      step_tile((i % GRID_W) * 16, (i / GRID_W) * 16, p);
      pulses += p;
    end
  endtask

  task automatic restart_level(input int mode, output int cycles);
    rom_mode = mode;
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    wait_init(cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pacman_pos_x = 11'd700; pacman_pos_y = 10'd0;
    score_clear = 1'b0; level_restart = 1'b0;
    rd_tile_x = 6'd1; rd_tile_y = 5'd0;
    rom_mode = 0;
    repeat (3) tick();
    n_vec++; if (score !== 12'd0) begin n_bad++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_vec++; if (pellets_left !== 11'd0) begin n_bad++; $display("FAIL reset_pellets: got %0d expected 0", pellets_left); end
    n_vec++; if (eat_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_eat: got %b expected 0", eat_pulse); end
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    n_vec++; if (level_clear !== 1'b0) begin n_bad++; $display("FAIL reset_level_clear: got %b expected 0", level_clear); end
    n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL reset_rd_pellet: got %b expected 0", rd_pellet); end
    n_vec++; if (wall_addr !== 11'd0) begin n_bad++; $display("FAIL reset_wall_addr: got %0d expected 0", wall_addr); end
  endtask

  task automatic test_init();
    int cycles = 0;
    rst = 1'b0;
    while (!init_done && cycles < 3000) begin
      tick();
      cycles++;
      if (cycles == 5) begin
        n_vec++; if (wall_addr !== 11'd5) begin n_bad++; $display("FAIL init_wall_addr: got %0d expected 5", wall_addr); end
      end
      if (cycles == 100) begin
        n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL init_rd_gated: got %b expected 0", rd_pellet); end
      end
    end
    n_vec++; if (cycles != 1201) begin n_bad++; $display("FAIL init_cycles: got %0d expected 1201", cycles); end
    n_vec++; if (pellets_left !== 11'd1199) begin n_bad++; $display("FAIL init_pellets: got %0d expected 1199", pellets_left); end
    n_vec++; if (level_clear !== 1'b0) begin n_bad++; $display("FAIL init_level_clear: got %b expected 0", level_clear); end
    rd_tile_x = 6'd0; rd_tile_y = 5'd0; tick();
    n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL rd_0_0: got %b expected 0", rd_pellet); end
    rd_tile_x = 6'd1; rd_tile_y = 5'd0; tick();
    n_vec++; if (rd_pellet !== 1'b1) begin n_bad++; $display("FAIL rd_1_0: got %b expected 1", rd_pellet); end
    rd_tile_x = 6'd45; rd_tile_y = 5'd0; tick();
    n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL rd_x_range: got %b expected 0", rd_pellet); end
    rd_tile_x = 6'd10; rd_tile_y = 5'd31; tick();
    n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL rd_y_range: got %b expected 0", rd_pellet); end
    rd_tile_x = 6'd0; rd_tile_y = 5'd29; tick();
    n_vec++; if (rd_pellet !== 1'b1) begin n_bad++; $display("FAIL rd_0_29: got %b expected 1", rd_pellet); end
  endtask

  task automatic test_eat();
    pacman_pos_x = 11'd160; pacman_pos_y = 10'd32;
    tick();
    n_vec++; if (eat_pulse !== 1'b0) begin n_bad++; $display("FAIL eat_t0: got %b expected 0", eat_pulse); end
    tick();
    n_vec++; if (eat_pulse !== 1'b0) begin n_bad++; $display("FAIL eat_t1: got %b expected 0", eat_pulse); end
    tick();
    n_vec++; if (eat_pulse !== 1'b1) begin n_bad++; $display("FAIL eat_t2: got %b expected 1", eat_pulse); end
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL eat_score: got %0d expected 1", score); end
    n_vec++; if (pellets_left !== 11'd1198) begin n_bad++; $display("FAIL eat_pellets: got %0d expected 1198", pellets_left); end
    tick();
    n_vec++; if (eat_pulse !== 1'b0) begin n_bad++; $display("FAIL eat_t3: got %b expected 0", eat_pulse); end
    rd_tile_x = 6'd10; rd_tile_y = 5'd2; tick();
    n_vec++; if (rd_pellet !== 1'b0) begin n_bad++; $display("FAIL eat_rd_10_2: got %b expected 0", rd_pellet); end
    rd_tile_x = 6'd11; rd_tile_y = 5'd2; tick();
    n_vec++; if (rd_pellet !== 1'b1) begin n_bad++; $display("FAIL eat_rd_11_2: got %b expected 1", rd_pellet); end
  endtask

  task automatic test_reenter();
    int p;
    step_tile(0, 0, p);
    n_vec++; if (p != 0) begin n_bad++; $display("FAIL reenter_wall_pulses: got %0d expected 0", p); end
    step_tile(160, 32, p);
    n_vec++; if (p != 0) begin n_bad++; $display("FAIL reenter_pulses: got %0d expected 0", p); end
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL reenter_score: got %0d expected 1", score); end
    n_vec++; if (pellets_left !== 11'd1198) begin n_bad++; $display("FAIL reenter_pellets: got %0d expected 1198", pellets_left); end
  endtask

  task automatic test_clear_on_eat();
    int p;
    pacman_pos_x = 11'd192; pacman_pos_y = 10'd32;
    tick();
    tick();
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
    n_vec++; if (eat_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_eat_pulse: got %b expected 1", eat_pulse); end
    n_vec++; if (score !== 12'd0) begin n_bad++; $display("FAIL clr_eat_score: got %0d expected 0", score); end
    n_vec++; if (pellets_left !== 11'd1197) begin n_bad++; $display("FAIL clr_eat_pellets: got %0d expected 1197", pellets_left); end
    step_tile(208, 32, p);
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL clr_after_score: got %0d expected 1", score); end
    score_clear = 1'b1;
    tick();
    score_clear = 1'b0;
    n_vec++; if (score !== 12'd0) begin n_bad++; $display("FAIL clr_idle_score: got %0d expected 0", score); end
    n_vec++; if (pellets_left !== 11'd1196) begin n_bad++; $display("FAIL clr_idle_pellets: got %0d expected 1196", pellets_left); end
    step_tile(224, 32, p);
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL clr_resume_score: got %0d expected 1", score); end
  endtask

  task automatic test_level_clear();
    int p;
    int cycles;
    rom_mode = 1;
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL lvl_restart_init_done: got %b expected 0", init_done); end
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL lvl_restart_score: got %0d expected 1", score); end
    wait_init(cycles);
    n_vec++; if (cycles != 1201) begin n_bad++; $display("FAIL lvl_init_cycles: got %0d expected 1201", cycles); end
    n_vec++; if (pellets_left !== 11'd1) begin n_bad++; $display("FAIL lvl_pellets: got %0d expected 1", pellets_left); end
    n_vec++; if (level_clear !== 1'b0) begin n_bad++; $display("FAIL lvl_clear_early: got %b expected 0", level_clear); end
    step_tile(80, 0, p);
    n_vec++; if (p != 1) begin n_bad++; $display("FAIL lvl_eat_pulses: got %0d expected 1", p); end
    n_vec++; if (pellets_left !== 11'd0) begin n_bad++; $display("FAIL lvl_pellets_zero: got %0d expected 0", pellets_left); end
    n_vec++; if (score !== 12'd2) begin n_bad++; $display("FAIL lvl_score: got %0d expected 2", score); end
    repeat (5) tick();
    n_vec++; if (level_clear !== 1'b1) begin n_bad++; $display("FAIL lvl_clear_sticky: got %b expected 1", level_clear); end
  endtask

  task automatic test_restart_sentinel();
    int p;
    int cycles;
    rom_mode = 2;
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    n_vec++; if (level_clear !== 1'b0) begin n_bad++; $display("FAIL rst_lvl_clear: got %b expected 0", level_clear); end
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_lvl_init_done: got %b expected 0", init_done); end
    n_vec++; if (score !== 12'd2) begin n_bad++; $display("FAIL rst_lvl_score: got %0d expected 2", score); end
    wait_init(cycles);
    n_vec++; if (pellets_left !== 11'd1200) begin n_bad++; $display("FAIL rst_lvl_pellets: got %0d expected 1200", pellets_left); end
    p = 0;
    repeat (4) begin
      tick();
      if (eat_pulse) p++;
    end
    n_vec++; if (p != 1) begin n_bad++; $display("FAIL sentinel_pulses: got %0d expected 1", p); end
    n_vec++; if (score !== 12'd3) begin n_bad++; $display("FAIL sentinel_score: got %0d expected 3", score); end
  endtask

  task automatic test_saturate();
    int p;
    int cycles;
    sweep(0, N_TILES - 1, p);
    n_vec++; if (p != 1199) begin n_bad++; $display("FAIL sat_l2_pulses: got %0d expected 1199", p); end
    n_vec++; if (score !== 12'd1202) begin n_bad++; $display("FAIL sat_l2_score: got %0d expected 1202", score); end
    n_vec++; if (level_clear !== 1'b1) begin n_bad++; $display("FAIL sat_l2_clear: got %b expected 1", level_clear); end
    step_tile(700, 0, p);
    restart_level(2, cycles);
    sweep(0, N_TILES - 1, p);
    n_vec++; if (score !== 12'd2402) begin n_bad++; $display("FAIL sat_l3_score: got %0d expected 2402", score); end
    step_tile(700, 0, p);
    restart_level(2, cycles);
    sweep(0, N_TILES - 1, p);
    n_vec++; if (score !== 12'd3602) begin n_bad++; $display("FAIL sat_l4_score: got %0d expected 3602", score); end
    step_tile(700, 0, p);
    restart_level(2, cycles);
    sweep(0, 492, p);
    n_vec++; if (score !== 12'd4095) begin n_bad++; $display("FAIL sat_reach_score: got %0d expected 4095", score); end
    step_tile(208, 192, p);
    n_vec++; if (p != 1) begin n_bad++; $display("FAIL sat_eat_pulses: got %0d expected 1", p); end
    n_vec++; if (score !== 12'd4095) begin n_bad++; $display("FAIL sat_hold_score: got %0d expected 4095", score); end
    n_vec++; if (pellets_left !== 11'd706) begin n_bad++; $display("FAIL sat_pellets: got %0d expected 706", pellets_left); end
  endtask

  task automatic test_out_of_range();
    int p;
    step_tile(700, 32, p);
    n_vec++; if (p != 0) begin n_bad++; $display("FAIL oor_x_pulses: got %0d expected 0", p); end
    step_tile(160, 480, p);
    n_vec++; if (p != 0) begin n_bad++; $display("FAIL oor_y_pulses: got %0d expected 0", p); end
    n_vec++; if (pellets_left !== 11'd706) begin n_bad++; $display("FAIL oor_pellets: got %0d expected 706", pellets_left); end
    step_tile(0, 464, p);
    n_vec++; if (p != 1) begin n_bad++; $display("FAIL edge_row_pulses: got %0d expected 1", p); end
    step_tile(624, 464, p);
    n_vec++; if (p != 1) begin n_bad++; $display("FAIL edge_corner_pulses: got %0d expected 1", p); end
    n_vec++; if (pellets_left !== 11'd704) begin n_bad++; $display("FAIL edge_pellets: got %0d expected 704", pellets_left); end
  endtask

  task automatic test_restart_and_clear();
    int cycles;
    pacman_pos_x = 11'd700; pacman_pos_y = 10'd0;
    score_clear = 1'b1;
    level_restart = 1'b1;
    tick();
    score_clear = 1'b0;
    level_restart = 1'b0;
    n_vec++; if (score !== 12'd0) begin n_bad++; $display("FAIL both_score: got %0d expected 0", score); end
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL both_init_done: got %b expected 0", init_done); end
    n_vec++; if (pellets_left !== 11'd0) begin n_bad++; $display("FAIL both_pellets: got %0d expected 0", pellets_left); end
    wait_init(cycles);
    n_vec++; if (cycles != 1201) begin n_bad++; $display("FAIL both_init_cycles: got %0d expected 1201", cycles); end
  endtask

  task automatic test_async_reset();
    int p;
    step_tile(32, 0, p);
    n_vec++; if (score !== 12'd1) begin n_bad++; $display("FAIL arst_pre_score: got %0d expected 1", score); end
    pacman_pos_x = 11'd16; pacman_pos_y = 10'd0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_vec++; if (score !== 12'd0) begin n_bad++; $display("FAIL arst_score: got %0d expected 0", score); end
    n_vec++; if (pellets_left !== 11'd0) begin n_bad++; $display("FAIL arst_pellets: got %0d expected 0", pellets_left); end
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL arst_init_done: got %b expected 0", init_done); end
    tick();
    n_vec++; if (eat_pulse !== 1'b0) begin n_bad++; $display("FAIL arst_eat: got %b expected 0", eat_pulse); end
    n_vec++; if (wall_addr !== 11'd0) begin n_bad++; $display("FAIL arst_wall_addr: got %0d expected 0", wall_addr); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_eat();
    test_reenter();
    test_clear_on_eat();
    test_level_clear();
    test_restart_sentinel();
    test_saturate();
    test_out_of_range();
    test_restart_and_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
